pong_draw_engine: RTL and testbench
===================================

// Module: pong_draw_engine
// PURPOSE
//  Multi-object rectangle renderer between the game logic and vga_adapter.
//  On each frame_tick it snapshots NUM_OBJ rectangles and, per object, erases
//  the previously drawn rectangle and plots the new one.
//  Output is one pixel per cycle on x/y/colour/plot, wired directly to vga_adapter.
//  Generalises fixed paddle/ball drawing to N objects of any size, colour
//  depth and resolution.
// PARAMETERS
//  NUM_OBJ    3          number of rectangle slots (paddle L, paddle R, ball)
//  XW         8          x coordinate width (160 px needs 8)
//  YW         7          y coordinate width (120 px needs 7)
//  SZW        5          per-object width/height field width
//  CW         3          colour width (3 x BITS_PER_COLOUR_CHANNEL)
//  H_RES      160        visible columns; pixels with x >= H_RES are clipped
//  V_RES      120        visible rows; pixels with y >= V_RES are clipped
//  BG_COLOUR  3'b000     erase colour
// PORTS
//  clock       in   1           system clock (CLOCK_50)
//  resetn      in   1           asynchronous active-low reset
//  frame_tick  in   1           1-cycle start request
//  obj_en      in   NUM_OBJ     slot i is visible
//  obj_x       in   NUM_OBJ*XW  top-left x; slot i at [i*XW +: XW]
//  obj_y       in   NUM_OBJ*YW  top-left y
//  obj_w       in   NUM_OBJ*SZW width in pixels
//  obj_h       in   NUM_OBJ*SZW height in pixels
//  obj_colour  in   NUM_OBJ*CW  fill colour
//  x           out  XW          pixel x to vga_adapter
//  y           out  YW          pixel y to vga_adapter
//  colour      out  CW          pixel colour
//  plot        out  1           write strobe, one pixel per cycle
//  busy        out  1           high from the cycle after accepted tick until done
//  done        out  1           1-cycle pulse when the frame completes
//  overrun     out  1           sticky: frame_tick arrived while busy
// BEHAVIOUR
//  - Reset (async, resetn=0): x=0, y=0, colour=0, plot=0, busy=0, done=0, overrun=0.
//    All per-slot "drawn" flags and stored old rectangles clear; state goes to IDLE.
//    Reset mid-frame abandons the frame and emits no further pixels.
//  - FSM: IDLE -> SNAP -> (per slot i=0..NUM_OBJ-1: CHECK -> ERASE -> DRAW) -> FIN -> IDLE.
//  - IDLE: frame_tick=1 -> SNAP. All obj_* inputs register in SNAP; later input
//    changes do not affect the frame.
//  - CHECK (1 cycle, plot=0): the new rect is the snapshot, gated by obj_en.
//    * Drawn flag set and old rect == new rect (x,y,w,h,colour, en=1): skip slot.
//    * Otherwise ERASE if the drawn flag is set, then DRAW if obj_en[i]=1.
//  - ERASE/DRAW: row-major raster, column inner. Pixel (ox+c, oy+r),
//    c<w, r<h. One pixel per cycle. ERASE uses BG_COLOUR; DRAW uses the slot colour.
//  - Arithmetic: ox+c and oy+r are computed at XW+1/YW+1 bits with no wrap.
//    A pixel with sum >= H_RES or >= V_RES drives plot=0 but still takes its cycle.
//  - w=0 or h=0: zero raster cycles. The slot records not drawn.
//  - After DRAW, old rect <= new rect and drawn flag <= 1. With obj_en=0 after
//    ERASE, drawn flag <= 0.
//  - Latency: tick at cycle T -> busy=1 at T+1; first plot no earlier than T+3.
//    Total cycles = 3 + NUM_OBJ + sum of rasterised pixel counts.
//  - FIN: done=1 for one cycle, busy drops the same cycle, then IDLE.
//  - frame_tick while busy is ignored and sets overrun, which clears only on reset.
//    frame_tick in the FIN cycle is also ignored.
//  - x/y/colour hold their last values when plot=0.
// CONFIGURATION
//  DRAW_CLEAR_EN defined: the first accepted frame after reset is preceded by a
//    full-screen clear. H_RES*V_RES cycles of BG_COLOUR, plot=1, row-major, then
//    the normal frame. busy stays high throughout.
//  Not defined: no clear pass. The screen relies on the adapter's BACKGROUND_IMAGE.
// TESTING
//  1. Reset, slot0 en, (10,20) w=2 h=3 col=3'b100, tick -> 6 plots.
//     Order (10,20)(11,20)(10,21)..(11,22), all colour 100; done after 3+3+6 cycles.
//  2. Same inputs, second tick -> no plots (unchanged skip); done at T+NUM_OBJ+3.
//  3. Move slot0 to (11,20), tick -> 6 erase plots colour 000 at old rect, then
//     6 draw plots at new rect.
//  4. Slot0 at (159,119) w=2 h=2 -> exactly one plot at (159,119); 4 raster cycles.
//  5. Tick again while busy -> overrun=1, frame unaffected; mid-frame resetn=0 ->
//     plot=0 immediately; next frame draws without erase.
//  6. DRAW_CLEAR_EN: first tick -> 19200 plots colour 000 before object plots;
//     second tick -> no clear pass.

Source files
------------

// File: rtl/pong_draw_engine_if.sv
// Bus between game logic and pong_draw_engine: rectangle slots in, pixel stream and status out.
// The engine connects through the slave modport, the game logic (or bench) through master.
interface pong_draw_engine_if #(
    parameter int unsigned NUM_OBJ = 3,
    parameter int unsigned XW      = 8,
    parameter int unsigned YW      = 7,
    parameter int unsigned SZW     = 5,
    parameter int unsigned CW      = 3
);
    logic                   frame_tick;
    logic [NUM_OBJ-1:0]     obj_en;
    logic [NUM_OBJ*XW-1:0]  obj_x;
    logic [NUM_OBJ*YW-1:0]  obj_y;
    logic [NUM_OBJ*SZW-1:0] obj_w;
    logic [NUM_OBJ*SZW-1:0] obj_h;
    logic [NUM_OBJ*CW-1:0]  obj_colour;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [CW-1:0]          colour;
    logic                   plot;
    logic                   busy;
    logic                   done;
    logic                   overrun;

    modport master (
        output frame_tick, obj_en, obj_x, obj_y, obj_w, obj_h, obj_colour,
        input  x, y, colour, plot, busy, done, overrun
    );

    modport slave (
        input  frame_tick, obj_en, obj_x, obj_y, obj_w, obj_h, obj_colour,
        output x, y, colour, plot, busy, done, overrun
    );
endinterface

// File: rtl/pong_draw_engine.sv
// Multi-object rectangle renderer feeding vga_adapter, one pixel per cycle.
// Each accepted frame_tick snapshots all slots, then per slot erases the old rectangle
// and draws the new one, skipping slots that have not changed.
// Optional macro DRAW_CLEAR_EN: full-screen background clear before the first frame after reset.
module pong_draw_engine #(
    parameter int unsigned   NUM_OBJ   = 3,
    parameter int unsigned   XW        = 8,
    parameter int unsigned   YW        = 7,
    parameter int unsigned   SZW       = 5,
    parameter int unsigned   CW        = 3,
    parameter int unsigned   H_RES     = 160,
    parameter int unsigned   V_RES     = 120,
    parameter logic [CW-1:0] BG_COLOUR = '0
) (
    input logic               clock,
    input logic               resetn,
    pong_draw_engine_if.slave bus
);

    localparam int unsigned    SLW       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam logic [SLW-1:0] LAST_SLOT = SLW'(NUM_OBJ - 1);
    localparam logic [XW:0]    H_LIM     = (XW + 1)'(H_RES);
    localparam logic [YW:0]    V_LIM     = (YW + 1)'(V_RES);

    typedef enum logic [2:0] {StIdle, StClear, StSnap, StCheck, StErase, StDraw, StFin} state_e;

    state_e r_state, w_state_d, w_after_slot;

    // Frame snapshot and last-drawn rectangle per slot
    logic [NUM_OBJ-1:0] r_sn_en;
    logic [XW-1:0]      r_sn_x   [NUM_OBJ];
    logic [YW-1:0]      r_sn_y   [NUM_OBJ];
    logic [SZW-1:0]     r_sn_w   [NUM_OBJ];
    logic [SZW-1:0]     r_sn_h   [NUM_OBJ];
    logic [CW-1:0]      r_sn_col [NUM_OBJ];
    logic [NUM_OBJ-1:0] r_drawn;
    logic [XW-1:0]      r_old_x   [NUM_OBJ];
    logic [YW-1:0]      r_old_y   [NUM_OBJ];
    logic [SZW-1:0]     r_old_w   [NUM_OBJ];
    logic [SZW-1:0]     r_old_h   [NUM_OBJ];
    logic [CW-1:0]      r_old_col [NUM_OBJ];

    logic [SLW-1:0] r_slot;
    logic [SZW-1:0] r_col, r_row;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [CW-1:0]  r_colour;
    logic           r_plot, r_busy, r_done, r_overrun;

`ifdef DRAW_CLEAR_EN
    localparam logic [XW-1:0] CLR_XL = XW'(H_RES - 1);
    localparam logic [YW-1:0] CLR_YL = YW'(V_RES - 1);
    logic [XW-1:0] r_cx;
    logic [YW-1:0] r_cy;
    logic          r_cleared;
    logic          w_clr_end;
    assign w_clr_end = (r_cx == CLR_XL) && (r_cy == CLR_YL);
`endif

    logic           w_nen, w_same, w_new_ok;
    logic [XW-1:0]  w_bx;
    logic [YW-1:0]  w_by;
    logic [SZW-1:0] w_bw, w_bh;
    logic [CW-1:0]  w_bcol;
    logic [XW:0]    w_sx;
    logic [YW:0]    w_sy;
    logic           w_col_last, w_row_last, w_rast_end, w_on_screen;
    logic [XW-1:0]  w_x_d;
    logic [YW-1:0]  w_y_d;
    logic [CW-1:0]  w_colour_d;
    logic           w_plot_d;

    // Slot classification for the CHECK decision
    assign w_nen    = r_sn_en[r_slot];
    assign w_new_ok = w_nen && (r_sn_w[r_slot] != '0) && (r_sn_h[r_slot] != '0);
    assign w_same   = r_drawn[r_slot] && w_nen
                   && (r_old_x[r_slot] == r_sn_x[r_slot]) && (r_old_y[r_slot] == r_sn_y[r_slot])
                   && (r_old_w[r_slot] == r_sn_w[r_slot]) && (r_old_h[r_slot] == r_sn_h[r_slot])
                   && (r_old_col[r_slot] == r_sn_col[r_slot]);
    assign w_after_slot = (r_slot == LAST_SLOT) ? StFin : StCheck;

    // Raster source: old rectangle while erasing, snapshot while drawing
    always_comb begin
        w_bx   = r_sn_x[r_slot];
        w_by   = r_sn_y[r_slot];
        w_bw   = r_sn_w[r_slot];
        w_bh   = r_sn_h[r_slot];
        w_bcol = r_sn_col[r_slot];
        if (r_state == StErase) begin
            w_bx   = r_old_x[r_slot];
            w_by   = r_old_y[r_slot];
            w_bw   = r_old_w[r_slot];
            w_bh   = r_old_h[r_slot];
            w_bcol = BG_COLOUR;
        end
    end

    // Sums carry one extra bit so off-screen pixels clip instead of wrapping
    assign w_sx        = {1'b0, w_bx} + (XW + 1)'(r_col);
    assign w_sy        = {1'b0, w_by} + (YW + 1)'(r_row);
    assign w_on_screen = (w_sx < H_LIM) && (w_sy < V_LIM);
    assign w_col_last  = (r_col == w_bw - SZW'(1));
    assign w_row_last  = (r_row == w_bh - SZW'(1));
    assign w_rast_end  = w_col_last && w_row_last;

    // FSM state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= StIdle;
        else         r_state <= w_state_d;
    end

    // Next state and next pixel output
    always_comb begin
        w_state_d  = r_state;
        w_plot_d   = 1'b0;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_colour_d = r_colour;
        case (r_state)
            StIdle: begin
                // a tick in the done cycle is dropped
                if (bus.frame_tick && !r_done) begin
`ifdef DRAW_CLEAR_EN
                    w_state_d = r_cleared ? StSnap : StClear;
`else
                    w_state_d = StSnap;
`endif
                end
            end
`ifdef DRAW_CLEAR_EN
            StClear: begin
                w_plot_d   = 1'b1;
                w_x_d      = r_cx;
                w_y_d      = r_cy;
                w_colour_d = BG_COLOUR;
                if (w_clr_end) w_state_d = StSnap;
            end
`endif
            StSnap:  w_state_d = StCheck;
            StCheck: begin
                if (w_same)              w_state_d = w_after_slot;
                else if (r_drawn[r_slot]) w_state_d = StErase;
                else if (w_new_ok)        w_state_d = StDraw;
                else                      w_state_d = w_after_slot;
            end
            StErase, StDraw: begin
                if (w_on_screen) begin
                    w_plot_d   = 1'b1;
                    w_x_d      = w_sx[XW-1:0];
                    w_y_d      = w_sy[YW-1:0];
                    w_colour_d = w_bcol;
                end
                if (w_rast_end) begin
                    w_state_d = (r_state == StErase && w_new_ok) ? StDraw : w_after_slot;
                end
            end
            StFin:   w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Datapath: snapshot, raster counters, slot bookkeeping and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_slot    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_colour  <= '0;
            r_plot    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_sn_en   <= '0;
            r_drawn   <= '0;
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                r_sn_x[i]    <= '0;
                r_sn_y[i]    <= '0;
                r_sn_w[i]    <= '0;
                r_sn_h[i]    <= '0;
                r_sn_col[i]  <= '0;
                r_old_x[i]   <= '0;
                r_old_y[i]   <= '0;
                r_old_w[i]   <= '0;
                r_old_h[i]   <= '0;
                r_old_col[i] <= '0;
            end
`ifdef DRAW_CLEAR_EN
            r_cx      <= '0;
            r_cy      <= '0;
            r_cleared <= 1'b0;
`endif
        end else begin
            r_plot   <= w_plot_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_colour <= w_colour_d;
            r_done   <= (r_state == StFin);
            if (r_state == StIdle && w_state_d != StIdle) r_busy <= 1'b1;
            else if (r_state == StFin)                    r_busy <= 1'b0;
            if (bus.frame_tick && r_busy) r_overrun <= 1'b1;
            case (r_state)
`ifdef DRAW_CLEAR_EN
                StClear: begin
                    if (r_cx == CLR_XL) begin
                        r_cx <= '0;
                        r_cy <= (r_cy == CLR_YL) ? '0 : r_cy + YW'(1);
                    end else begin
                        r_cx <= r_cx + XW'(1);
                    end
                    if (w_clr_end) r_cleared <= 1'b1;
                end
`endif
                StSnap: begin
                    r_sn_en <= bus.obj_en;
                    for (int i = 0; i < int'(NUM_OBJ); i++) begin
                        r_sn_x[i]   <= bus.obj_x[i*XW +: XW];
                        r_sn_y[i]   <= bus.obj_y[i*YW +: YW];
                        r_sn_w[i]   <= bus.obj_w[i*SZW +: SZW];
                        r_sn_h[i]   <= bus.obj_h[i*SZW +: SZW];
                        r_sn_col[i] <= bus.obj_colour[i*CW +: CW];
                    end
                    r_slot <= '0;
                    r_col  <= '0;
                    r_row  <= '0;
                end
                StCheck: begin
                    r_col <= '0;
                    r_row <= '0;
                    if (w_state_d == StCheck || w_state_d == StFin) r_slot <= r_slot + SLW'(1);
                end
                StErase, StDraw: begin
                    if (w_col_last) begin
                        r_col <= '0;
                        r_row <= w_row_last ? '0 : r_row + SZW'(1);
                    end else begin
                        r_col <= r_col + SZW'(1);
                    end
                    if (w_rast_end) begin
                        if (r_state == StDraw) begin
                            r_old_x[r_slot]   <= r_sn_x[r_slot];
                            r_old_y[r_slot]   <= r_sn_y[r_slot];
                            r_old_w[r_slot]   <= r_sn_w[r_slot];
                            r_old_h[r_slot]   <= r_sn_h[r_slot];
                            r_old_col[r_slot] <= r_sn_col[r_slot];
                            r_drawn[r_slot]   <= 1'b1;
                            r_slot            <= r_slot + SLW'(1);
                        end else begin
                            r_drawn[r_slot] <= 1'b0;
                            if (!w_new_ok) r_slot <= r_slot + SLW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.x       = r_x;
    assign bus.y       = r_y;
    assign bus.colour  = r_colour;
    assign bus.plot    = r_plot;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.overrun = r_overrun;

endmodule

// File: tb/tb_pong_draw_engine.sv
// Bench for pong_draw_engine: directed vector table, hand-written corner sequences,
// and randomized frames compared against a pixel-list reference model.
module tb_pong_draw_engine;
    localparam int unsigned NUM_OBJ = 3;
    localparam int unsigned XW      = 8;
    localparam int unsigned YW      = 7;
    localparam int unsigned SZW     = 5;
    localparam int unsigned CW      = 3;
    localparam int unsigned H_RES   = 160;
    localparam int unsigned V_RES   = 120;
    localparam int          BG      = 0;
`ifdef DRAW_CLEAR_EN
    localparam int CLR = H_RES * V_RES;
`else
    localparam int CLR = 0;
`endif

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    pong_draw_engine_if #(.NUM_OBJ(NUM_OBJ), .XW(XW), .YW(YW), .SZW(SZW), .CW(CW)) bus ();

    pong_draw_engine #(
        .NUM_OBJ(NUM_OBJ), .XW(XW), .YW(YW), .SZW(SZW), .CW(CW),
        .H_RES(H_RES), .V_RES(V_RES), .BG_COLOUR(3'b000)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Stimulus per slot and model memory of what is on screen
    int s_en[NUM_OBJ], s_x[NUM_OBJ], s_y[NUM_OBJ], s_w[NUM_OBJ], s_h[NUM_OBJ], s_col[NUM_OBJ];
    int m_drawn[NUM_OBJ], m_x[NUM_OBJ], m_y[NUM_OBJ], m_w[NUM_OBJ], m_h[NUM_OBJ], m_col[NUM_OBJ];
    bit m_cleared;
    int exp_q[$];
    int got_q[$];

    typedef struct {
        int en; int x; int y; int w; int h; int col;
        int plots; int lat;
    } vec_t;
    vec_t tbl[8];

    function automatic int pix(input int px, input int py, input int pc);
        return (px << 16) | (py << 8) | pc;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic model_rect(input int ox, input int oy, input int w, input int h, input int c);
        for (int r = 0; r < h; r++)
            for (int cc = 0; cc < w; cc++)
                if (ox + cc < int'(H_RES) && oy + r < int'(V_RES)) exp_q.push_back(pix(ox + cc, oy + r, c));
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(NUM_OBJ); i++) m_drawn[i] = 0;
        m_cleared = 0;
    endtask

    // Expected pixel list for one frame; returns the number of raster cycles
    task automatic model_frame(output int cyc);
        cyc = 0;
        exp_q.delete();
`ifdef DRAW_CLEAR_EN
        if (!m_cleared) begin
            model_rect(0, 0, H_RES, V_RES, BG);
            cyc += H_RES * V_RES;
            m_cleared = 1;
        end
`endif
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            if (m_drawn[i] != 0 && s_en[i] != 0 && m_x[i] == s_x[i] && m_y[i] == s_y[i] &&
                m_w[i] == s_w[i] && m_h[i] == s_h[i] && m_col[i] == s_col[i]) continue;
            if (m_drawn[i] != 0) begin
                model_rect(m_x[i], m_y[i], m_w[i], m_h[i], BG);
                cyc += m_w[i] * m_h[i];
                m_drawn[i] = 0;
            end
            if (s_en[i] != 0 && s_w[i] > 0 && s_h[i] > 0) begin
                model_rect(s_x[i], s_y[i], s_w[i], s_h[i], s_col[i]);
                cyc += s_w[i] * s_h[i];
                m_x[i] = s_x[i]; m_y[i] = s_y[i]; m_w[i] = s_w[i]; m_h[i] = s_h[i];
                m_col[i] = s_col[i];
                m_drawn[i] = 1;
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < int'(NUM_OBJ); i++) begin
            bus.obj_en[i]                  = (s_en[i] != 0);
            bus.obj_x[i*XW +: XW]          = XW'(s_x[i]);
            bus.obj_y[i*YW +: YW]          = YW'(s_y[i]);
            bus.obj_w[i*SZW +: SZW]        = SZW'(s_w[i]);
            bus.obj_h[i*SZW +: SZW]        = SZW'(s_h[i]);
            bus.obj_colour[i*CW +: CW]     = CW'(s_col[i]);
        end
    endtask

    task automatic scramble_inputs();
        bus.obj_en     = NUM_OBJ'($urandom);
        bus.obj_x      = (NUM_OBJ * XW)'($urandom);
        bus.obj_y      = (NUM_OBJ * YW)'($urandom);
        bus.obj_w      = (NUM_OBJ * SZW)'($urandom);
        bus.obj_h      = (NUM_OBJ * SZW)'($urandom);
        bus.obj_colour = (NUM_OBJ * CW)'($urandom);
    endtask

    // Tick one frame, collect plots until done, compare with the model
    task automatic run_frame(input string tag, input int inject_k, input bit inject_done,
                             input bit scramble, output int nplots, output int lat);
        int pcyc, exp_lat, first_bad;
        model_frame(pcyc);
        exp_lat = 3 + NUM_OBJ + pcyc;
        got_q.delete();
        lat = -1;
        drive_inputs();
        @(posedge clock); #1 bus.frame_tick = 1'b1;
        @(posedge clock); #1 bus.frame_tick = 1'b0;
        check({tag, "_busy_t1"}, int'(bus.busy), 1);
        for (int k = 1; k <= exp_lat + 20; k++) begin
            if (k > 1) begin
                @(posedge clock); #1;
                bus.frame_tick = 1'b0;
            end
            if (bus.plot) got_q.push_back(pix(int'(bus.x), int'(bus.y), int'(bus.colour)));
            if (bus.done) begin
                lat = k;
                check({tag, "_busy_at_done"}, int'(bus.busy), 0);
                if (inject_done) bus.frame_tick = 1'b1;
                break;
            end
            if (scramble && k == 2) scramble_inputs();
            if (k == inject_k) bus.frame_tick = 1'b1;
        end
        if (bus.frame_tick) begin
            @(posedge clock); #1 bus.frame_tick = 1'b0;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_nplots"}, got_q.size(), exp_q.size());
        first_bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] != exp_q[i]) begin first_bad = i; break; end
        if (first_bad >= 0)
            $display("  pixel %0d: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d", first_bad,
                     got_q[first_bad] >> 16, (got_q[first_bad] >> 8) & 255, got_q[first_bad] & 255,
                     exp_q[first_bad] >> 16, (exp_q[first_bad] >> 8) & 255, exp_q[first_bad] & 255);
        check({tag, "_first_bad_pixel"}, first_bad, -1);
        nplots = got_q.size();
        drive_inputs();
    endtask

    task automatic set_slot0_only(input int en, input int x, input int y, input int w, input int h,
                                  input int col);
        for (int i = 1; i < int'(NUM_OBJ); i++) begin
            s_en[i] = 0; s_x[i] = 0; s_y[i] = 0; s_w[i] = 0; s_h[i] = 0; s_col[i] = 0;
        end
        s_en[0] = en; s_x[0] = x; s_y[0] = y; s_w[0] = w; s_h[0] = h; s_col[0] = col;
    endtask

    initial begin
        int np, lat;
        bus.frame_tick = 1'b0;
        bus.obj_en = '0; bus.obj_x = '0; bus.obj_y = '0;
        bus.obj_w = '0; bus.obj_h = '0; bus.obj_colour = '0;
        set_slot0_only(0, 0, 0, 0, 0, 0);
        model_reset();

        #1;
        check("rst_x", int'(bus.x), 0);
        check("rst_y", int'(bus.y), 0);
        check("rst_colour", int'(bus.colour), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_overrun", int'(bus.overrun), 0);
        #20 resetn = 1'b1;

        // en x y w h col | plots latency (clear pass excluded)
        tbl = '{
            '{1,  10,  20, 2, 3, 4,  6, 12},
            '{1,  10,  20, 2, 3, 4,  0,  6},
            '{1,  11,  20, 2, 3, 4, 12, 18},
            '{1, 159, 119, 2, 2, 2,  7, 16},
            '{1, 159, 119, 2, 2, 2,  0,  6},
            '{0, 159, 119, 2, 2, 2,  1, 10},
            '{0, 159, 119, 2, 2, 2,  0,  6},
            '{1,   5,   5, 0, 3, 1,  0,  6}
        };
        for (int i = 0; i < 8; i++) begin
            set_slot0_only(tbl[i].en, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].col);
            run_frame($sformatf("tbl%0d", i), -1, 1'b0, 1'b0, np, lat);
            check($sformatf("tbl%0d_plots_const", i), np, tbl[i].plots + ((i == 0) ? CLR : 0));
            check($sformatf("tbl%0d_lat_const", i), lat, tbl[i].lat + ((i == 0) ? CLR : 0));
        end

        // Tick in the done cycle is ignored and does not flag overrun
        set_slot0_only(1, 30, 30, 1, 1, 5);
        run_frame("done_tick", -1, 1'b1, 1'b0, np, lat);
        repeat (3) @(posedge clock);
        #1;
        check("done_tick_busy", int'(bus.busy), 0);
        check("done_tick_overrun", int'(bus.overrun), 0);

        // Tick mid-frame: frame unchanged, overrun sticks
        set_slot0_only(1, 40, 40, 3, 3, 3);
        run_frame("overrun", 4, 1'b0, 1'b1, np, lat);
        check("overrun_plots_const", np, 10);
        check("overrun_set", int'(bus.overrun), 1);
        set_slot0_only(1, 40, 40, 3, 3, 3);
        run_frame("overrun_hold", -1, 1'b0, 1'b0, np, lat);
        check("overrun_sticky", int'(bus.overrun), 1);

        // Reset in the middle of a frame stops plotting at once
        set_slot0_only(1, 50, 50, 8, 8, 6);
        drive_inputs();
        @(posedge clock); #1 bus.frame_tick = 1'b1;
        @(posedge clock); #1 bus.frame_tick = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("midrst_plot_before", int'(bus.plot), 1);
        resetn = 1'b0;
        #1;
        check("midrst_plot", int'(bus.plot), 0);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_overrun", int'(bus.overrun), 0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        model_reset();
        run_frame("after_rst", -1, 1'b0, 1'b0, np, lat);
        check("after_rst_plots_const", np, 64 + CLR);

        // Randomized frames over all slots
        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < int'(NUM_OBJ); i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    s_en[i]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
                    s_x[i]   = int'($urandom_range(0, 255));
                    s_y[i]   = int'($urandom_range(0, 127));
                    s_w[i]   = int'($urandom_range(0, 6));
                    s_h[i]   = int'($urandom_range(0, 6));
                    s_col[i] = int'($urandom_range(0, 7));
                end
            end
            run_frame($sformatf("rnd%0d", f),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : -1,
                      1'b0, 1'($urandom_range(0, 1)), np, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
